// File: rtl/alu_pkg.sv
// Shared ALU/divider definitions: opcodes, divider FSM states and flag bit positions.
package alu_pkg;

    // Instruction opcode that routes to the divider, and the ALU op it decodes to
    localparam logic [4:0] DIV  = 5'b01000;
    localparam logic [2:0] DIVA = 3'b011;

    // Bit positions inside the 2-bit flags result
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } div_state_t;

endpackage

// File: rtl/alu_div_unit_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor, and keep the difference only when
// it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+2:0] diff_s;

    // Trial subtraction; the top bit of diff_s is the borrow
    always_comb begin
        shifted_s = {rem_in, bit_in};
        diff_s    = {1'b0, shifted_s} - {3'b000, divisor};
        if (diff_s[WIDTH+2]) begin
            rem_out = shifted_s[WIDTH:0];
            q_bit   = 1'b0;
        end else begin
            rem_out = diff_s[WIDTH:0];
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/alu_div_unit.sv
// Iterative restoring divider answering the ALU's DIV requests.
// BPC quotient bits are resolved per clock by a chain of div_step instances.
// Optional macro ALU_DIV_SIGNED_EN: two's-complement operands with a FIXUP
// state that restores result signs (one extra cycle of latency).
module alu_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       flags,
    output logic             dbz
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    div_state_t         state_r, next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   dvd_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH:0]     rem_r;      // partial remainder with borrow headroom
    logic               dbz_r;
    logic               busy_r, done_r, dbz_out_r;
    logic [WIDTH-1:0]   quotient_r, remainder_r;
    logic [1:0]         flags_r;

    logic [BPC:0][WIDTH:0] rem_chain_s;
    logic [BPC-1:0]        qbits_s;
    logic [WIDTH-1:0]      step_dvd_s;
    logic [WIDTH-1:0]      res_q_s, res_rem_s;
    logic [1:0]            res_flags_s;
    logic                  accept_s;

`ifdef ALU_DIV_SIGNED_EN
    logic neg_q_r, neg_r_r;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_val = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            abs_val = v;
        end
    endfunction
`endif

    assign rem_chain_s[0] = rem_r;

    genvar g;
    generate
        for (g = 0; g < BPC; g++) begin : g_step
            div_step #(.WIDTH(WIDTH)) u_step (
                .rem_in  (rem_chain_s[g]),
                .bit_in  (dvd_r[WIDTH-1-g]),
                .divisor (dvs_r),
                .rem_out (rem_chain_s[g+1]),
                .q_bit   (qbits_s[BPC-1-g])
            );
        end
    endgenerate

    // Result candidates published on the DONE edge, including divide-by-zero override
    always_comb begin
        accept_s   = start & ~flush;
        step_dvd_s = {dvd_r[WIDTH-BPC-1:0], qbits_s};
        if (dbz_r) begin
            res_q_s   = {WIDTH{1'b1}};
            res_rem_s = dvd_r;
        end else begin
            res_q_s   = dvd_r;
            res_rem_s = rem_r[WIDTH-1:0];
        end
        res_flags_s         = 2'b00;
        res_flags_s[FLAG_Z] = (res_q_s == {WIDTH{1'b0}});
        res_flags_s[FLAG_N] = res_q_s[WIDTH-1];
    end

    // Next-state logic; flush always wins and returns to IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = CALC;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
`ifdef ALU_DIV_SIGNED_EN
                    next_state_s = FIXUP;
`else
                    next_state_s = DONE;
`endif
                end else begin
                    next_state_s = CALC;
                end
            end
`ifdef ALU_DIV_SIGNED_EN
            FIXUP: begin
                if (flush) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
`endif
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_out_r   <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            flags_r     <= 2'b00;
`ifdef ALU_DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r <= CNT_W'(STEPS - 1);
                        rem_r <= {(WIDTH+1){1'b0}};
                        dbz_r <= (divisor == {WIDTH{1'b0}});
`ifdef ALU_DIV_SIGNED_EN
                        dvs_r   <= abs_val(divisor);
                        neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_r <= dividend[WIDTH-1];
                        // Divide-by-zero returns the raw dividend as remainder
                        if (divisor == {WIDTH{1'b0}}) begin
                            dvd_r <= dividend;
                        end else begin
                            dvd_r <= abs_val(dividend);
                        end
`else
                        dvs_r <= divisor;
                        dvd_r <= dividend;
`endif
                    end
                end
                CALC: begin
                    if (!flush) begin
                        dvd_r <= step_dvd_s;
                        rem_r <= rem_chain_s[BPC];
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
`ifdef ALU_DIV_SIGNED_EN
                FIXUP: begin
                    if (!flush) begin
                        if (neg_q_r) begin
                            dvd_r <= ~dvd_r + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                        if (neg_r_r) begin
                            rem_r <= ~rem_r + {{WIDTH{1'b0}}, 1'b1};
                        end
                    end
                end
`endif
                DONE: begin
                    // Results are published only when the request completes unflushed
                    if (!flush) begin
                        done_r      <= 1'b1;
                        quotient_r  <= res_q_s;
                        remainder_r <= res_rem_s;
                        flags_r     <= res_flags_s;
                        dbz_out_r   <= dbz_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign flags     = flags_r;
    assign dbz       = dbz_out_r;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed self-checking bench for alu_div_unit (unsigned by default,
// signed scenarios when ALU_DIV_SIGNED_EN is defined).
module tb_alu_div_unit;

    localparam int WIDTH = 32;
`ifdef ALU_DIV_SIGNED_EN
    localparam int BPC = 2;
    localparam int LAT = WIDTH / BPC + 2;
`else
    localparam int BPC = 1;
    localparam int LAT = WIDTH / BPC + 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] dividend = 32'd0;
    logic [WIDTH-1:0] divisor = 32'd0;
    logic             busy, done, dbz;
    logic [WIDTH-1:0] quotient, remainder;
    logic [1:0]       flags;

    int errors = 0;
    int checks = 0;
    int lat;
    int done_cnt;
    logic busy_seen;

    alu_div_unit #(.WIDTH(WIDTH), .BPC(BPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .flags(flags), .dbz(dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Issue one request and measure edges from the start edge to done (0 = timeout)
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int l);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_seen = busy;
        l = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                l = k;
                break;
            end
        end
    endtask

    // Count done pulses over a number of cycles
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({busy, done, dbz, flags} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, dbz, flags}); end
        checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL reset_data: got q=%h r=%h expected 0/0", quotient, remainder); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        run_div(32'd100, 32'd7, lat);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", busy_seen); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL t1_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL t1_quotient: got %h expected %h", quotient, 32'd14); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL t1_remainder: got %h expected %h", remainder, 32'd2); end
        checks++; if ({flags, dbz} !== 3'b000) begin errors++; $display("FAIL t1_flags_dbz: got %b expected 000", {flags, dbz}); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_div_by_zero();
        run_div(32'd5, 32'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL t2_latency: got %0d expected 1", lat); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL t2_quotient: got %h expected ffffffff", quotient); end
        checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL t2_remainder: got %h expected 5", remainder); end
        checks++; if ({flags, dbz} !== 3'b101) begin errors++; $display("FAIL t2_flags_dbz: got %b expected 101", {flags, dbz}); end
    endtask

    task automatic test_edges();
        run_div(32'd3, 32'd10, lat);
        checks++; if (quotient !== 32'd0 || remainder !== 32'd3) begin errors++; $display("FAIL t3_small: got q=%h r=%h expected 0/3", quotient, remainder); end
        checks++; if (flags !== 2'b01 || dbz !== 1'b0) begin errors++; $display("FAIL t3_zero_flag: got flags=%b dbz=%b expected 01/0", flags, dbz); end
        run_div(32'hFFFF_FFFF, 32'd1, lat);
        checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin errors++; $display("FAIL t3_max: got q=%h r=%h expected ffffffff/0", quotient, remainder); end
        checks++; if (flags !== 2'b10) begin errors++; $display("FAIL t3_neg_flag: got %b expected 10", flags); end
    endtask

    task automatic test_flush_and_ignore();
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_flush_busy: got %b expected 0", busy); end
        count_done(LAT + 10, done_cnt);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL t4_flush_no_done: got %0d pulses expected 0", done_cnt); end
        checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin errors++; $display("FAIL t4_flush_hold: got q=%h r=%h expected ffffffff/0", quotient, remainder); end
        run_div(32'd9, 32'd3, lat);
        checks++; if (lat !== LAT || quotient !== 32'd3 || remainder !== 32'd0) begin errors++; $display("FAIL t4_after_flush: got lat=%0d q=%h r=%h expected %0d/3/0", lat, quotient, remainder, LAT); end
        dividend = 32'd20; divisor = 32'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 dividend = 32'd99; divisor = 32'd2; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        count_done(LAT + 20, done_cnt);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t4_ignored_start: got %0d pulses expected 1", done_cnt); end
        checks++; if (quotient !== 32'd5 || remainder !== 32'd0) begin errors++; $display("FAIL t4_ignored_result: got q=%h r=%h expected 5/0", quotient, remainder); end
    endtask

    task automatic test_reset_mid_op();
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, dbz, flags} !== 5'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin errors++; $display("FAIL t5_async_reset: got ctrl=%b q=%h r=%h expected all 0", {busy, done, dbz, flags}, quotient, remainder); end
        @(posedge clk); #1 rst_n = 1'b1;
        count_done(LAT + 5, done_cnt);
        checks++; if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL t5_no_done: got %0d pulses busy=%b expected 0/0", done_cnt, busy); end
        run_div(32'd50, 32'd5, lat);
        checks++; if (lat !== LAT || quotient !== 32'd10 || remainder !== 32'd0) begin errors++; $display("FAIL t5_rerun: got lat=%0d q=%h r=%h expected %0d/a/0", lat, quotient, remainder, LAT); end
    endtask

`ifdef ALU_DIV_SIGNED_EN
    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, lat);
        checks++; if (lat !== 18) begin errors++; $display("FAIL t6_latency: got %0d expected 18", lat); end
        checks++; if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin errors++; $display("FAIL t6_neg7_div2: got q=%h r=%h expected fffffffd/ffffffff", quotient, remainder); end
        checks++; if (flags !== 2'b10) begin errors++; $display("FAIL t6_flags: got %b expected 10", flags); end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++; if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin errors++; $display("FAIL t6_minint: got q=%h r=%h expected 80000000/0", quotient, remainder); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_edges();
        test_flush_and_ignore();
        test_reset_mid_op();
`ifdef ALU_DIV_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
